mips_bus_memory: RTL and testbench
==================================

MIPS_BUS_MEMORY -- requirements
Module: mips_bus_memory

Interface
REQ-001 Parameter BASE_ADDR, default 32'hBFC00000, byte address of memory word 0.
REQ-002 Parameter DEPTH_WORDS, default 64, number of 32-bit words stored.
REQ-003 Parameter WAIT_CYCLES, default 2, waitrequest-high cycles inserted per access (0..15).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low; 0 resets control state immediately.
REQ-006 address  input  32  byte address from CPU.
REQ-007 write  input  1  write request.
REQ-008 read  input  1  read request.
REQ-009 writedata  input  32  write data.
REQ-010 byteenable  input  4  bit i enables byte lane writedata[8i+7:8i].
REQ-011 waitrequest  output  1  stall; request not accepted while high.
REQ-012 readdata  output  32  registered read data.
REQ-013 bus_error  output  1  sticky protocol/range error flag.
REQ-014 load_en  input  1  backdoor word write, bench preload only.
REQ-015 load_addr  input  log2(DEPTH_WORDS)  backdoor word index.
REQ-016 load_data  input  32  backdoor data.

Function
REQ-017 Word index = (address - BASE_ADDR) >> 2; address[1:0] ignored.
REQ-018 Address in range when BASE_ADDR <= address < BASE_ADDR + 4*DEPTH_WORDS, unsigned compare.
REQ-019 States: IDLE, WAIT, ACCESS; 4-bit wait counter.
REQ-020 IDLE: read|write high and WAIT_CYCLES>0 -> WAIT, counter=1; WAIT_CYCLES=0 -> ACCESS behaviour in same cycle.
REQ-021 WAIT: counter increments each cycle; counter==WAIT_CYCLES -> ACCESS.
REQ-022 waitrequest = (read|write) and state != ACCESS and WAIT_CYCLES != 0; combinational from state and requests.
REQ-023 Accept edge = rising edge with (read|write) high and waitrequest low; ACCESS returns to IDLE after it.
REQ-024 Request deasserted while in WAIT -> IDLE, counter=0, no access performed.
REQ-025 Accepted write, in range: each enabled byte lane written; disabled lanes unchanged; byteenable 4'b0000 writes nothing.
REQ-026 Accepted read, in range: readdata <= memory word at next edge; readdata holds until next accepted read.
REQ-027 Accepted read, address == 0 or out of range: readdata <= 0.
REQ-028 Accepted write out of range: no memory change, bus_error <= 1.
REQ-029 read and write both high: write performed only, readdata unchanged, bus_error <= 1.
REQ-030 Read-after-write to same word on consecutive accepts returns newly written data.
REQ-031 load_en high: memory[load_addr] <= load_data at edge; takes priority over a same-word bus write; does not affect state or waitrequest.
REQ-032 bus_error sticky; cleared only by reset.

Reset
REQ-033 reset=0: state IDLE, counter 0, readdata 32'h0, bus_error 0, immediately without clock.
REQ-034 waitrequest follows REQ-022 during reset (high if request present and WAIT_CYCLES>0).
REQ-035 Memory contents unaffected by reset; power-up contents all zero.
REQ-036 Reset mid-WAIT aborts access; no write committed.

Verification
REQ-037 WAIT_CYCLES=2, preload word 1 = 32'h8D09002C, read 32'hBFC00004 -> waitrequest high 2 cycles, accept on 3rd edge, readdata 32'h8D09002C next cycle.
REQ-038 Word 3 = 32'h11223344, write 32'hAABBCCDD byteenable 4'b0101 to 32'hBFC0000C, read back -> 32'h11BB33DD.
REQ-039 Read address 0 and 32'h00001000 -> readdata 0; write 32'h00001000 -> bus_error 1, memory unchanged.
REQ-040 WAIT_CYCLES=0, back-to-back write then read word 5 (data 32'hFFFF0000) -> waitrequest never high, readdata 32'hFFFF0000.
REQ-041 Assert read 1 cycle into WAIT then drop; separately reset low mid-write wait -> state IDLE, no memory change, readdata 0 after reset.
REQ-042 read and write both high to word 2 with 32'h0000000F -> word 2 = 32'h0000000F, readdata unchanged, bus_error 1.

Source files
------------

// File: rtl/mips_bus_memory.sv
// Word-addressed memory slave on a CPU bus with a fixed number of wait states.
// Accepts byte-lane writes, returns registered read data, and flags protocol/range errors.
module mips_bus_memory #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [31:0]                    address,
  input  logic                           write,
  input  logic                           read,
  input  logic [31:0]                    writedata,
  input  logic [3:0]                     byteenable,
  output logic                           waitrequest,
  output logic [31:0]                    readdata,
  output logic                           bus_error,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_N = 4'(WAIT_CYCLES);
  localparam logic [32:0] LIMIT  = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t        state_r;
  logic [3:0]    cnt_r;
  logic [3:0]    cnt_inc_s;
  logic [31:0]   mem_r [DEPTH_WORDS];
  logic          req_s;
  logic          accept_s;
  logic          in_range_s;
  logic          wr_commit_s;
  logic          load_hit_s;
  logic [31:0]   offset_s;
  logic [AW-1:0] idx_s;
  logic          unused_s;

  // Request decode, stall generation and address range check.
  always_comb begin
    req_s       = read | write;
    waitrequest = req_s && (state_r != ACCESS) && (WAIT_N != 4'd0);
    accept_s    = req_s && !waitrequest;
    offset_s    = address - BASE_ADDR;
    idx_s       = offset_s[AW+1:2];
    in_range_s  = ({1'b0, address} >= {1'b0, BASE_ADDR}) && ({1'b0, address} < LIMIT);
    wr_commit_s = accept_s && write && in_range_s;
    load_hit_s  = load_en && (load_addr == idx_s);
    cnt_inc_s   = cnt_r + 4'd1;
    unused_s    = ^{offset_s[31:AW+2], offset_s[1:0]};
  end

  // Wait-state sequencing plus registered read data and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      readdata  <= 32'h0000_0000;
      bus_error <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s && (WAIT_N != 4'd0)) begin
            // A single wait state is the IDLE cycle itself, so go straight to ACCESS.
            state_r <= (WAIT_N == 4'd1) ? ACCESS : WAIT;
            cnt_r   <= 4'd1;
          end else begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
          end
        end
        WAIT: begin
          if (!req_s) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
          end else if (cnt_inc_s == WAIT_N) begin
            state_r <= ACCESS;
            cnt_r   <= cnt_inc_s;
          end else begin
            state_r <= WAIT;
            cnt_r   <= cnt_inc_s;
          end
        end
        ACCESS: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
        end
      endcase

      if (accept_s) begin
        if (write) begin
          if (read || !in_range_s) begin
            bus_error <= 1'b1;
          end
        end else if (in_range_s && (address != 32'h0000_0000)) begin
          readdata <= mem_r[idx_s];
        end else begin
          readdata <= 32'h0000_0000;
        end
      end
    end
  end

  // Storage: backdoor load wins over a bus write to the same word.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_r[load_addr] <= load_data;
    end
    if (wr_commit_s && !load_hit_s) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) begin
          mem_r[idx_s][8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_bus_memory.sv
// Directed bench for mips_bus_memory: a 2-wait-state instance driven from a vector
// table, and a zero-wait-state instance sharing the same inputs for back-to-back cases.
module tb_mips_bus_memory;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [31:0] load_data;

  logic        wr2, err2, wr0, err0;
  logic [31:0] rd2, rd0;

  int checks = 0;
  int errors = 0;

  mips_bus_memory #(.BASE_ADDR(32'hBFC00000), .DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .address(address), .write(write), .read(read),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(wr2),
    .readdata(rd2), .bus_error(err2), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data)
  );

  mips_bus_memory #(.BASE_ADDR(32'hBFC00000), .DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .address(address), .write(write), .read(read),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(wr0),
    .readdata(rd0), .bus_error(err0), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic        rd;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_word(input logic [5:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  // Drive one request on the 2-wait instance; called at posedge+1, returns at posedge+1.
  task automatic do_access(input logic [31:0] a, input logic w, input logic r,
                           input logic [31:0] d, input logic [3:0] be, output int waits);
    address = a; write = w; read = r; writedata = d; byteenable = be;
    waits = 0;
    #1;
    while (wr2 && waits < 20) begin
      waits++;
      @(posedge clk); #2;
    end
    if (waits >= 20) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: waitrequest stuck high at address %h", a);
    end
    @(posedge clk); #1;
    write = 1'b0; read = 1'b0;
  endtask

  initial begin
    int waits;
    reset = 1'b1; address = 32'h0; write = 1'b0; read = 1'b0;
    writedata = 32'h0; byteenable = 4'h0; load_en = 1'b0; load_addr = 6'd0; load_data = 32'h0;

    vecs[0]  = '{32'hBFC00004, 1'b0, 1'b1, 32'h00000000, 4'h0, 32'h8D09002C, 1'b0};
    vecs[1]  = '{32'hBFC0000C, 1'b1, 1'b0, 32'hAABBCCDD, 4'h5, 32'h8D09002C, 1'b0};
    vecs[2]  = '{32'hBFC0000C, 1'b0, 1'b1, 32'h00000000, 4'h0, 32'h11BB33DD, 1'b0};
    vecs[3]  = '{32'hBFC00010, 1'b1, 1'b0, 32'h12345678, 4'h0, 32'h11BB33DD, 1'b0};
    vecs[4]  = '{32'hBFC00012, 1'b0, 1'b1, 32'h00000000, 4'h0, 32'hCAFEF00D, 1'b0};
    vecs[5]  = '{32'hBFC00018, 1'b1, 1'b0, 32'hDEADBEEF, 4'hF, 32'hCAFEF00D, 1'b0};
    vecs[6]  = '{32'hBFC00018, 1'b0, 1'b1, 32'h00000000, 4'h0, 32'hDEADBEEF, 1'b0};
    vecs[7]  = '{32'hBFC000FC, 1'b0, 1'b1, 32'h00000000, 4'h0, 32'h0A0B0C0D, 1'b0};
    vecs[8]  = '{32'hBFC00100, 1'b0, 1'b1, 32'h00000000, 4'h0, 32'h00000000, 1'b0};
    vecs[9]  = '{32'hBFC000FC, 1'b0, 1'b1, 32'h00000000, 4'h0, 32'h0A0B0C0D, 1'b0};
    vecs[10] = '{32'h00000000, 1'b0, 1'b1, 32'h00000000, 4'h0, 32'h00000000, 1'b0};
    vecs[11] = '{32'h00001000, 1'b0, 1'b1, 32'h00000000, 4'h0, 32'h00000000, 1'b0};
    vecs[12] = '{32'h00001000, 1'b1, 1'b0, 32'h12345678, 4'hF, 32'h00000000, 1'b1};
    vecs[13] = '{32'hBFC00000, 1'b0, 1'b1, 32'h00000000, 4'h0, 32'h55AA55AA, 1'b1};
    vecs[14] = '{32'hBFC00008, 1'b1, 1'b1, 32'h0000000F, 4'hF, 32'h55AA55AA, 1'b1};
    vecs[15] = '{32'hBFC00008, 1'b0, 1'b1, 32'h00000000, 4'h0, 32'h0000000F, 1'b1};

    // Asynchronous reset, and waitrequest still live while reset is held.
    #1 reset = 1'b0;
    #1;
    chk("reset_readdata", rd2, 32'h0);
    chk("reset_bus_error", {31'h0, err2}, 32'h0);
    read = 1'b1;
    #1;
    chk("reset_wait_w2", {31'h0, wr2}, 32'h1);
    chk("reset_wait_w0", {31'h0, wr0}, 32'h0);
    read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    load_word(6'd0, 32'h55AA55AA);
    load_word(6'd1, 32'h8D09002C);
    load_word(6'd2, 32'h00000000);
    load_word(6'd3, 32'h11223344);
    load_word(6'd4, 32'hCAFEF00D);
    load_word(6'd5, 32'h00000000);
    load_word(6'd7, 32'h77777777);
    load_word(6'd8, 32'h00000000);
    load_word(6'd63, 32'h0A0B0C0D);

    for (int i = 0; i < 16; i++) begin
      do_access(vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].wdata, vecs[i].be, waits);
      chk($sformatf("v%0d_waits", i), 32'(waits), 32'd2);
      chk($sformatf("v%0d_readdata", i), rd2, vecs[i].exp_rd);
      chk($sformatf("v%0d_bus_error", i), {31'h0, err2}, {31'h0, vecs[i].exp_err});
    end

    // Request dropped one cycle into WAIT: no access, full wait sequence afterwards.
    address = 32'hBFC00004; read = 1'b1;
    #1 chk("abort_wait_high", {31'h0, wr2}, 32'h1);
    @(posedge clk); #1;
    read = 1'b0;
    #1 chk("abort_wait_low", {31'h0, wr2}, 32'h0);
    @(posedge clk); #1;
    chk("abort_readdata_hold", rd2, 32'h0000000F);
    do_access(32'hBFC00004, 1'b0, 1'b1, 32'h0, 4'h0, waits);
    chk("abort_then_waits", 32'(waits), 32'd2);
    chk("abort_then_readdata", rd2, 32'h8D09002C);

    // Reset in the middle of a write's wait period.
    address = 32'hBFC0001C; write = 1'b1; writedata = 32'h00000000; byteenable = 4'hF;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("midreset_readdata", rd2, 32'h0);
    chk("midreset_bus_error", {31'h0, err2}, 32'h0);
    chk("midreset_wait", {31'h0, wr2}, 32'h1);
    write = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    do_access(32'hBFC0001C, 1'b0, 1'b1, 32'h0, 4'h0, waits);
    chk("midreset_waits", 32'(waits), 32'd2);
    chk("midreset_mem", rd2, 32'h77777777);

    // Zero-wait instance: backdoor load beats a same-word bus write on the same edge.
    address = 32'hBFC00020; write = 1'b1; writedata = 32'h22222222; byteenable = 4'hF;
    load_en = 1'b1; load_addr = 6'd8; load_data = 32'h11111111;
    #1 chk("w0_load_wait", {31'h0, wr0}, 32'h0);
    @(posedge clk); #1;
    write = 1'b0; load_en = 1'b0;
    read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    chk("w0_load_priority", rd0, 32'h11111111);
    @(posedge clk); #1;

    // Zero-wait instance: back-to-back write then read of word 5.
    address = 32'hBFC00014; write = 1'b1; writedata = 32'hFFFF0000; byteenable = 4'hF;
    #1 chk("w0_b2b_wait_wr", {31'h0, wr0}, 32'h0);
    @(posedge clk); #1;
    write = 1'b0; read = 1'b1;
    #1 chk("w0_b2b_wait_rd", {31'h0, wr0}, 32'h0);
    @(posedge clk); #1;
    read = 1'b0;
    chk("w0_b2b_readdata", rd0, 32'hFFFF0000);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
